// File: rtl/neuron_seq_mac.sv
// Time-multiplexed neuron: one shared signed multiplier accumulates
// sum(in[k]*w[k]) + bias over N_IN cycles, then applies either a
// piecewise-linear (PLAN) sigmoid or a step activation.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for an input transaction
// MAC   | one product per cycle accumulated, idx walks 0..N_IN-1
// ACT   | activation evaluated on the final sum, outputs registered
// DONE  | result held on out_* until the consumer takes it
module neuron_seq_mac #(
    parameter int N_IN   = 7,
    parameter int IN_W   = 17,
    parameter int FRAC_W = 8,
    parameter int BIAS_W = 24,
    parameter int OUT_W  = 8,
    localparam int ACC_W = 2*IN_W + $clog2(N_IN+1) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*IN_W-1:0]     in_vec,
    input  logic [N_IN*IN_W-1:0]     w_vec,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic                     act_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_act,
    output logic signed [ACC_W-1:0]  out_sum
);

    localparam int F     = 2*FRAC_W;
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN-1);

    // Sigmoid breakpoints and offsets in units of 2^-F
    localparam logic [ACC_W-1:0] ONE_C  = ACC_W'(1) << F;
    localparam logic [ACC_W-1:0] HALF_C = ONE_C >> 1;
    localparam logic [ACC_W-1:0] T2_C   = (ONE_C * ACC_W'(19)) >> 3;
    localparam logic [ACC_W-1:0] FIVE_C = ONE_C * ACC_W'(5);
    localparam logic [ACC_W-1:0] OFS2_C = (ONE_C * ACC_W'(5)) >> 3;
    localparam logic [ACC_W-1:0] OFS3_C = (ONE_C * ACC_W'(27)) >> 5;
    localparam logic [ACC_W-1:0] SAT_C  = (ACC_W'(1) << OUT_W) - ACC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     act_sel_q, act_sel_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [N_IN*IN_W-1:0]     in_vec_q, in_vec_d;
    logic [N_IN*IN_W-1:0]     w_vec_q, w_vec_d;
    logic [OUT_W-1:0]         out_act_q, out_act_d;
    logic signed [ACC_W-1:0]  out_sum_q, out_sum_d;

    logic signed [IN_W-1:0]   op_a, op_b;
    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, bias_ext;

    logic                     acc_neg, acc_pos;
    logic [ACC_W-1:0]         acc_u, mag, y_pos, y, y_sh;
    logic [OUT_W-1:0]         act_sig, act_val;

    assign op_a     = in_vec_q[int'(idx_q)*IN_W +: IN_W];
    assign op_b     = w_vec_q[int'(idx_q)*IN_W +: IN_W];
    assign prod     = (2*IN_W)'(op_a) * (2*IN_W)'(op_b);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias);

    // Activation of the current accumulator; magnitude is taken in ACC_W
    // unsigned bits so the most negative sum still has a valid |acc|.
    always_comb begin
        acc_u   = acc_q;
        acc_neg = acc_q[ACC_W-1];
        acc_pos = !acc_neg && (acc_q != '0);
        mag     = acc_neg ? (~acc_u + ACC_W'(1)) : acc_u;
        if (mag < ONE_C)       y_pos = (mag >> 2) + HALF_C;
        else if (mag < T2_C)   y_pos = (mag >> 3) + OFS2_C;
        else if (mag < FIVE_C) y_pos = (mag >> 5) + OFS3_C;
        else                   y_pos = ONE_C;
        y       = acc_neg ? (ONE_C - y_pos) : y_pos;
        y_sh    = y >> (F - OUT_W);
        act_sig = (y_sh > SAT_C) ? {OUT_W{1'b1}} : y_sh[OUT_W-1:0];
        act_val = act_sel_q ? (acc_pos ? {OUT_W{1'b1}} : {OUT_W{1'b0}}) : act_sig;
    end

    // Next-state and datapath updates for the sequencing FSM
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        act_sel_d   = act_sel_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        in_vec_d    = in_vec_q;
        w_vec_d     = w_vec_q;
        out_act_d   = out_act_q;
        out_sum_d   = out_sum_q;
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    in_vec_d   = in_vec;
                    w_vec_d    = w_vec;
                    act_sel_d  = act_sel;
                    acc_d      = bias_ext;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                out_sum_d   = acc_q;
                out_act_d   = act_val;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            act_sel_q   <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_vec_q    <= '0;
            w_vec_q     <= '0;
            out_act_q   <= '0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            act_sel_q   <= act_sel_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in_vec_q    <= in_vec_d;
            w_vec_q     <= w_vec_d;
            out_act_q   <= out_act_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_act   = out_act_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Scoreboard bench for neuron_seq_mac: stimulus pushes hand-computed
// expected results, a negedge monitor pops and compares on each output
// transfer and checks the accept-to-valid latency.
module tb_neuron_seq_mac;

    localparam int N_IN   = 7;
    localparam int IN_W   = 17;
    localparam int BIAS_W = 24;
    localparam int OUT_W  = 8;
    localparam int ACC_W  = 38;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [N_IN*IN_W-1:0]     in_vec = '0;
    logic [N_IN*IN_W-1:0]     w_vec = '0;
    logic signed [BIAS_W-1:0] bias = '0;
    logic                     act_sel = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [OUT_W-1:0]         out_act;
    logic signed [ACC_W-1:0]  out_sum;

    neuron_seq_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .w_vec     (w_vec),
        .bias      (bias),
        .act_sel   (act_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [ACC_W-1:0] sum;
        logic [OUT_W-1:0]        act;
        int                      acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    bit   prev_v = 1'b0;

    logic signed [IN_W-1:0] vi[N_IN];
    logic signed [IN_W-1:0] vw[N_IN];

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < N_IN; k++) begin
            vi[k] = '0;
            vw[k] = '0;
        end
    endtask

    task automatic send(input logic signed [BIAS_W-1:0] b, input logic sel,
                        input logic signed [ACC_W-1:0] es, input logic [OUT_W-1:0] ea,
                        input bit push);
        exp_t e;
        bit   rdy;
        bit   done;
        done = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            in_vec[k*IN_W +: IN_W] = vi[k];
            w_vec[k*IN_W +: IN_W]  = vw[k];
        end
        bias     = b;
        act_sel  = sel;
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never seen high, expected accept within 60 cycles");
        end else if (push) begin
            e.sum     = es;
            e.act     = ea;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        // Scramble operands after accept: the result must use latched copies.
        in_valid = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            in_vec[k*IN_W +: IN_W] = IN_W'($urandom);
            w_vec[k*IN_W +: IN_W]  = IN_W'($urandom);
        end
        bias    = BIAS_W'($urandom);
        act_sel = ~sel;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clk);
        #1;
    endtask

    // Monitor: latency check on each rising out_valid, value check on each transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got out_sum=%0d with no transaction pending, expected none", out_sum);
                end else begin
                    chk("latency", longint'(cyc - sb[0].acc_cyc), 64'sd8);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                me = sb.pop_front();
                chk("out_sum", out_sum, me.sum);
                chk("out_act", longint'(out_act), longint'(me.act));
            end
            prev_v = out_valid;
        end
    end

    initial begin
        bit bad;
        clr();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_act", longint'(out_act), 0);
        chk("rst_out_sum", out_sum, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", longint'(in_ready), 1);

        // Zero operands, sigmoid(0) = 0.5
        clr();
        send(24'sd0, 1'b0, 38'sd0, 8'd128, 1'b1);

        // Single product +-1.0
        clr();
        vi[0] = 17'sd256; vw[0] = 17'sd256;
        send(24'sd0, 1'b0, 38'sd65536, 8'd192, 1'b1);
        vw[0] = -17'sd256;
        send(24'sd0, 1'b0, -38'sd65536, 8'd64, 1'b1);

        // Saturation and segment boundaries via bias
        clr();
        send(24'sd393216, 1'b0, 38'sd393216, 8'd255, 1'b1);
        send(-24'sd393216, 1'b0, -38'sd393216, 8'd0, 1'b1);
        send(24'sd65535, 1'b0, 38'sd65535, 8'd191, 1'b1);
        send(24'sd155647, 1'b0, 38'sd155647, 8'd235, 1'b1);
        send(24'sd155648, 1'b0, 38'sd155648, 8'd235, 1'b1);
        send(24'sd327679, 1'b0, 38'sd327679, 8'd255, 1'b1);
        send(24'sd32768, 1'b0, 38'sd32768, 8'd160, 1'b1);
        send(-24'sd32768, 1'b0, -38'sd32768, 8'd96, 1'b1);

        // All seven lanes: +1 -2 +3 -4 +5 -6 +7 = 4.0
        for (int k = 0; k < N_IN; k++) begin
            vi[k] = IN_W'(256 * (k + 1));
            vw[k] = (k % 2 == 0) ? 17'sd256 : -17'sd256;
        end
        send(24'sd0, 1'b0, 38'sd262144, 8'd248, 1'b1);

        // Most negative operands everywhere: 7 * 2^32 exact
        for (int k = 0; k < N_IN; k++) begin
            vi[k] = 17'h10000;
            vw[k] = 17'h10000;
        end
        send(24'sd0, 1'b0, 38'sd30064771072, 8'd255, 1'b1);

        // Step activation
        clr();
        send(24'sd0, 1'b1, 38'sd0, 8'd0, 1'b1);
        send(24'sd1, 1'b1, 38'sd1, 8'd255, 1'b1);
        send(-24'sd1, 1'b1, -38'sd1, 8'd0, 1'b1);
        for (int k = 0; k < N_IN - 1; k++) vi[k] = 17'sd5;
        vi[6] = 17'sd2; vw[6] = 17'sd3;
        send(24'sd0, 1'b1, 38'sd6, 8'd255, 1'b1);

        // Back-pressure: result held, in_valid ignored while DONE
        drain();
        out_ready = 1'b0;
        clr();
        vi[1] = 17'sd512; vw[1] = 17'sd128;
        send(24'sd65536, 1'b0, 38'sd131072, 8'd224, 1'b1);
        for (int t = 0; t < 30 && !out_valid; t++) @(negedge clk);
        chk("bp_out_valid_seen", longint'(out_valid), 1);
        for (int t = 0; t < 5; t++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_vec   = {N_IN{17'h00123}};
            w_vec    = {N_IN{17'h00456}};
            @(negedge clk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_sum", out_sum, 38'sd131072);
            chk("bp_out_act", longint'(out_act), 224);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of MAC discards the transaction
        clr();
        vi[0] = 17'sd256; vw[0] = 17'sd256;
        send(24'sd0, 1'b0, 38'sd65536, 8'd192, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no_valid_after_reset", longint'(bad), 0);
        chk("in_ready_after_midrst", longint'(in_ready), 1);

        // Recovery transaction
        @(posedge clk);
        #1;
        clr();
        send(24'sd0, 1'b0, 38'sd0, 8'd128, 1'b1);
        drain();
        chk("scoreboard_empty", longint'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
